// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between two byte requesters, the arbiter and a UART transmitter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface uart_tx_arb_if;
  logic       req0_valid;
  logic       req1_valid;
  logic [7:0] req0_data;
  logic [7:0] req1_data;
  logic       req0_ready;
  logic       req1_ready;
  logic       tx_start;
  logic [7:0] tx_din;
  logic       tx_done_tick;
  logic       busy;
  logic       grant_id;
  logic       timeout_err;

  modport master (
    output req0_valid, req1_valid, req0_data, req1_data, tx_done_tick,
    input  req0_ready, req1_ready, tx_start, tx_din, busy, grant_id, timeout_err
  );

  modport slave (
    input  req0_valid, req1_valid, req0_data, req1_data, tx_done_tick,
    output req0_ready, req1_ready, tx_start, tx_din, busy, grant_id, timeout_err
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter feeding bytes from two requesters into one UART transmitter,
// with a frame timeout. Define UART_TX_ARB_TAG_EN to prefix each byte with a tag frame.
module uart_tx_arb #(
  parameter int unsigned TIMEOUT = 200000
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_arb_if.slave bus
);

  localparam logic [23:0] WAIT_LAST = 24'(TIMEOUT - 1);

`ifdef UART_TX_ARB_TAG_EN
  typedef enum logic [2:0] {IDLE, TAG_LAUNCH, TAG_WAIT, LAUNCH, WAIT} state_t;
  localparam state_t FIRST_LAUNCH = TAG_LAUNCH;
`else
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT} state_t;
  localparam state_t FIRST_LAUNCH = LAUNCH;
`endif

  state_t      state;
  state_t      next_state;
  logic [7:0]  byte_reg;
  logic        grant_q;
  logic        last_grant;
  logic [23:0] wait_cnt;
  logic        ready0;
  logic        ready1;
  logic        accept;
  logic        start;
  logic        timeout_hit;
  logic        in_wait;
  logic        in_launch;

`ifdef UART_TX_ARB_TAG_EN
  logic [7:0] tx_din_q;
  assign in_wait   = (state == WAIT)   || (state == TAG_WAIT);
  assign in_launch = (state == LAUNCH) || (state == TAG_LAUNCH);
`else
  assign in_wait   = (state == WAIT);
  assign in_launch = (state == LAUNCH);
`endif

  assign accept = ready0 || ready1;

  // NOTE: every output of this block gets a default first so no path leaves a
  // variable unassigned; that is what keeps synthesis from inferring latches.
  always_comb begin
    ready0      = 1'b0;
    ready1      = 1'b0;
    start       = 1'b0;
    timeout_hit = 1'b0;
    next_state  = state;
    unique case (state)
      IDLE: begin
        if (reset) begin
          if (bus.req0_valid && (!bus.req1_valid || last_grant)) ready0 = 1'b1;
          else if (bus.req1_valid)                               ready1 = 1'b1;
        end
        if (ready0 || ready1) next_state = FIRST_LAUNCH;
      end
      LAUNCH: begin
        start      = reset;
        next_state = WAIT;
      end
      WAIT: begin
        // A done tick on the last allowed cycle wins over the timeout.
        if (bus.tx_done_tick) begin
          next_state = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = reset;
          next_state  = IDLE;
        end
      end
`ifdef UART_TX_ARB_TAG_EN
      TAG_LAUNCH: begin
        start      = reset;
        next_state = TAG_WAIT;
      end
      TAG_WAIT: begin
        if (bus.tx_done_tick) begin
          next_state = LAUNCH;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout_hit = reset;
          next_state  = IDLE;
        end
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      byte_reg   <= 8'h00;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
`ifdef UART_TX_ARB_TAG_EN
      tx_din_q   <= 8'h00;
`endif
    end else begin
      state <= next_state;
      if (accept) begin
        byte_reg <= ready1 ? bus.req1_data : bus.req0_data;
        grant_q  <= ready1;
      end
      // The launch cycle clears the counter so each wait starts from zero.
      if (in_launch)
        wait_cnt <= '0;
      else if (in_wait && (wait_cnt != WAIT_LAST))
        wait_cnt <= wait_cnt + 24'd1;
      if (in_wait && (next_state == IDLE))
        last_grant <= grant_q;
`ifdef UART_TX_ARB_TAG_EN
      if (accept)
        tx_din_q <= {7'b1010000, ready1};
      else if ((state == TAG_WAIT) && (next_state == LAUNCH))
        tx_din_q <= byte_reg;
`endif
    end
  end

  assign bus.req0_ready  = ready0;
  assign bus.req1_ready  = ready1;
  assign bus.tx_start    = start;
  assign bus.busy        = (state != IDLE);
  assign bus.grant_id    = grant_q;
  assign bus.timeout_err = timeout_hit;
`ifdef UART_TX_ARB_TAG_EN
  assign bus.tx_din      = tx_din_q;
`else
  assign bus.tx_din      = byte_reg;
`endif

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: reset, single request, round-robin ties,
// timeout and its coincidence with done, reset mid-frame, and the tag build.
module tb_uart_tx_arb;
  localparam int unsigned TIMEOUT = 16;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;
  logic seen;

  uart_tx_arb_if bus ();

  uart_tx_arb #(.TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Returns one time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid   = 1'b0;
    bus.req1_valid   = 1'b0;
    bus.req0_data    = 8'h00;
    bus.req1_data    = 8'h00;
    bus.tx_done_tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1'b0;
    tick();
    tick();
    // Held in reset: outputs at reset values and ready suppressed.
    bus.req0_valid = 1'b1;
    #1;
    check("rst_ready0",  32'(bus.req0_ready),  0);
    check("rst_busy",    32'(bus.busy),        0);
    check("rst_start",   32'(bus.tx_start),    0);
    check("rst_grant",   32'(bus.grant_id),    0);
    check("rst_tx_din",  32'(bus.tx_din),      0);
    check("rst_timeout", 32'(bus.timeout_err), 0);
    bus.req0_valid = 1'b0;
    tick();
    reset = 1'b1;

`ifdef UART_TX_ARB_TAG_EN
    // req1 sends 0x3C: tag frame 0xA1 first, then the data byte.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h3C;
    #1;
    check("tag_ready1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    #1;
    check("tag_start1", 32'(bus.tx_start), 1);
    check("tag_din1",   32'(bus.tx_din),   'hA1);
    check("tag_grant",  32'(bus.grant_id), 1);
    tick();
    check("tag_wait_start", 32'(bus.tx_start), 0);
    check("tag_wait_din",   32'(bus.tx_din),   'hA1);
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    #1;
    check("tag_start2", 32'(bus.tx_start), 1);
    check("tag_din2",   32'(bus.tx_din),   'h3C);
    tick();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    #1;
    check("tag_end_busy",    32'(bus.busy),        0);
    check("tag_end_timeout", 32'(bus.timeout_err), 0);
`else
    // Single request right after reset.
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h55;
    #1;
    check("t1_ready0", 32'(bus.req0_ready), 1);
    check("t1_ready1", 32'(bus.req1_ready), 0);
    tick();
    bus.req0_data = 8'hFF;
    #1;
    check("t1_start",       32'(bus.tx_start),   1);
    check("t1_din",         32'(bus.tx_din),     'h55);
    check("t1_grant",       32'(bus.grant_id),   0);
    check("t1_launch_rdy0", 32'(bus.req0_ready), 0);
    tick();
    check("t1_wait_start", 32'(bus.tx_start),   0);
    check("t1_wait_din",   32'(bus.tx_din),     'h55);
    check("t1_wait_rdy0",  32'(bus.req0_ready), 0);
    check("t1_wait_busy",  32'(bus.busy),       1);
    bus.req0_valid   = 1'b0;
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
    #1;
    check("t1_idle_busy", 32'(bus.busy),   0);
    check("t1_idle_din",  32'(bus.tx_din), 'h55);

    // Both valid continuously: grants alternate 0,1,0,1.
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'h11;
    bus.req1_data  = 8'h22;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("rr%0d_ready0", i), 32'(bus.req0_ready), 1 - (i % 2));
      check($sformatf("rr%0d_ready1", i), 32'(bus.req1_ready), i % 2);
      tick();
      check($sformatf("rr%0d_start", i), 32'(bus.tx_start), 1);
      check($sformatf("rr%0d_din", i),   32'(bus.tx_din),   (i % 2 == 1) ? 'h22 : 'h11);
      check($sformatf("rr%0d_grant", i), 32'(bus.grant_id), i % 2);
      repeat (9) tick();
      bus.tx_done_tick = 1'b1;
      tick();
      bus.tx_done_tick = 1'b0;
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    check("rr_end_busy", 32'(bus.busy), 0);

    // Timeout: req0 frame never completes; error 16 cycles after tx_start.
    do_reset();
    bus.req0_valid = 1'b1;
    bus.req0_data  = 8'h77;
    #1;
    check("to_ready0", 32'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 1'b0;
    check("to_start", 32'(bus.tx_start), 1);
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin
      tick();
      seen = seen | bus.timeout_err;
    end
    check("to_early", 32'(seen), 0);
    tick();
    check("to_pulse",      32'(bus.timeout_err), 1);
    check("to_pulse_busy", 32'(bus.busy),        1);
    tick();
    check("to_after_err",  32'(bus.timeout_err), 0);
    check("to_after_busy", 32'(bus.busy),        0);

    // Tie after req0 timed out goes to req1; done during LAUNCH is ignored,
    // done on the timeout cycle counts as done.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'hA5;
    bus.req1_data  = 8'h5A;
    #1;
    check("co_ready0", 32'(bus.req0_ready), 0);
    check("co_ready1", 32'(bus.req1_ready), 1);
    tick();
    bus.req0_valid   = 1'b0;
    bus.req1_valid   = 1'b0;
    bus.tx_done_tick = 1'b1;
    #1;
    check("co_din",   32'(bus.tx_din),   'h5A);
    check("co_grant", 32'(bus.grant_id), 1);
    tick();
    bus.tx_done_tick = 1'b0;
    #1;
    check("co_launch_done_ignored", 32'(bus.busy), 1);
    repeat (15) tick();
    bus.tx_done_tick = 1'b1;
    #1;
    check("co_no_err", 32'(bus.timeout_err), 0);
    check("co_busy",   32'(bus.busy),        1);
    tick();
    bus.tx_done_tick = 1'b0;
    #1;
    check("co_idle_busy", 32'(bus.busy),        0);
    check("co_idle_err",  32'(bus.timeout_err), 0);

    // Tie after req1 finished goes to req0.
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'hC3;
    bus.req1_data  = 8'h3C;
    #1;
    check("rr2_ready0", 32'(bus.req0_ready), 1);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("rr2_din", 32'(bus.tx_din), 'hC3);
    tick();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;

    // Reset during a req1 frame: abandoned, and the next tie goes to req0.
    bus.req1_valid = 1'b1;
    bus.req1_data  = 8'h99;
    #1;
    check("mr_ready1", 32'(bus.req1_ready), 1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    tick();
    reset          = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    bus.req0_data  = 8'h12;
    bus.req1_data  = 8'h34;
    #1;
    check("mr_rst_err",    32'(bus.timeout_err), 0);
    check("mr_rst_ready0", 32'(bus.req0_ready),  0);
    check("mr_rst_ready1", 32'(bus.req1_ready),  0);
    tick();
    reset = 1'b1;
    #1;
    check("mr_busy",   32'(bus.busy),       0);
    check("mr_start",  32'(bus.tx_start),   0);
    check("mr_ready0", 32'(bus.req0_ready), 1);
    check("mr_ready1", 32'(bus.req1_ready), 0);
    tick();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check("mr_grant", 32'(bus.grant_id), 0);
    check("mr_din",   32'(bus.tx_din),   'h12);
    tick();
    bus.tx_done_tick = 1'b1;
    tick();
    bus.tx_done_tick = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter TIMEOUT, default 200000, SHALL set the number of clk cycles allowed from tx_start to tx_done_tick before abort (range 2..2^24-1).
REQ-002 Port clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port reset  in  1  SHALL be the reset: synchronous, active-low (0 = reset).
REQ-004 Ports req0_valid, req1_valid  in  1  SHALL each flag that the requester holds a byte to send.
REQ-005 Ports req0_data, req1_data  in  8  SHALL each carry that requester's byte.
REQ-006 Ports req0_ready, req1_ready  out  1  SHALL each indicate acceptance; a byte transfers in a cycle where valid and ready are both 1.
REQ-007 Port tx_start  out  1  SHALL be the one-cycle start pulse to the UART transmitter.
REQ-008 Port tx_din  out  8  SHALL be the byte presented to the transmitter.
REQ-009 Port tx_done_tick  in  1  SHALL be the transmitter's end-of-frame pulse.
REQ-010 Port busy  out  1  SHALL be 1 whenever state is not IDLE.
REQ-011 Port grant_id  out  1  SHALL identify the requester owning the current transfer (0 or 1).
REQ-012 Port timeout_err  out  1  SHALL pulse for one cycle when a frame is aborted on timeout.

Function
REQ-013 States SHALL be IDLE, TAG_LAUNCH, TAG_WAIT, LAUNCH, WAIT; TAG_* are reachable only per REQ-030.
REQ-014 In IDLE, if exactly one valid is 1, that requester's ready SHALL be 1 combinationally in the same cycle.
REQ-015 In IDLE with both valid, ready SHALL go to the requester other than last_grant (round-robin); the other ready stays 0.
REQ-016 Outside IDLE, both ready outputs SHALL be 0.
REQ-017 On acceptance, the block SHALL latch data into byte_reg, set grant_id to the winner, and go to LAUNCH (or TAG_LAUNCH per REQ-030).
REQ-018 tx_start SHALL be 1 exactly in the single cycle spent in LAUNCH or TAG_LAUNCH, then move to WAIT or TAG_WAIT.
REQ-019 tx_din SHALL equal byte_reg in LAUNCH/WAIT, hold its last value in IDLE, and change only on state entry.
REQ-020 Latency: acceptance in cycle N SHALL give tx_start in cycle N+1 (no tag).
REQ-021 In WAIT, tx_done_tick=1 SHALL return to IDLE next cycle and set last_grant=grant_id; next acceptance is possible in that IDLE cycle.
REQ-022 A wait counter SHALL clear on entry to WAIT/TAG_WAIT and increment each cycle there; reaching TIMEOUT-1 without tx_done_tick SHALL pulse timeout_err, go to IDLE, and update last_grant.
REQ-023 tx_done_tick and timeout in the same cycle SHALL be treated as done; no timeout_err.
REQ-024 tx_done_tick in IDLE, LAUNCH or TAG_LAUNCH SHALL be ignored.
REQ-025 Counter width SHALL be 24 bits; it SHALL never wrap within one wait.
REQ-026 Changes on req*_data/valid after acceptance SHALL not affect the byte in flight.

Reset
REQ-027 With reset=0 at a rising edge: state=IDLE, tx_start=0, timeout_err=0, busy=0, grant_id=0, tx_din=8'h00, counter=0, last_grant=1 (req0 wins first tie).
REQ-028 Reset mid-transfer SHALL abandon the transfer with no timeout_err and no ready pulse in that cycle.
REQ-029 ready outputs SHALL be 0 while reset=0.

Configuration
REQ-030 Macro UART_TX_ARB_TAG_EN defined: each accepted byte SHALL be preceded by a tag frame: TAG_LAUNCH drives tx_din=8'hA0|grant_id with tx_start, TAG_WAIT awaits tx_done_tick (same timeout), then LAUNCH sends byte_reg; a timeout in TAG_WAIT drops the data byte.
REQ-031 Macro undefined: TAG states and their logic SHALL be absent; acceptance goes straight to LAUNCH.

Verification
REQ-032 After reset, req0_valid=1 data 8'h55 -> req0_ready=1 same cycle, tx_start next cycle, tx_din=8'h55, grant_id=0.
REQ-033 Both valid continuously (8'h11, 8'h22), done 10 cycles after each start -> grants alternate 0,1,0,1; tx_din 11,22,11,22.
REQ-034 TIMEOUT=16, never assert tx_done_tick -> timeout_err pulses once 16 cycles after tx_start entry to WAIT, busy drops next cycle.
REQ-035 tx_done_tick coincident with timeout cycle -> no timeout_err, normal return to IDLE.
REQ-036 reset=0 during WAIT -> next cycle IDLE, busy=0, tx_start=0; subsequent tie grants req0.
REQ-037 With UART_TX_ARB_TAG_EN, req1 sends 8'h3C -> two tx_start pulses: tx_din=8'hA1 then 8'h3C.
